// File: rtl/fixed_mult_pkg.sv
// Shared types and the Q-format normalise/saturate helper for sm_fixed_mult_seq.
// SM_MULT_SATURATE_EN selects saturation instead of wrap on overflow.
`timescale 1ns/1ps
package fixed_mult_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef SM_MULT_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        ovf;
        logic [63:0] mag;
    } norm_t;

    // r is the already-shifted product, zero-extended; bits at or above out_w are overflow.
    function automatic norm_t normalise(input logic [63:0] r, input int unsigned out_w);
        logic [63:0] mask;
        norm_t       res;
        mask    = (out_w >= 64) ? '1 : ((64'd1 << out_w) - 64'd1);
        res.ovf = |(r & ~mask);
        res.mag = (res.ovf && SAT_EN) ? mask : (r & mask);
        return res;
    endfunction

endpackage

// File: rtl/sm_fixed_mult_seq.sv
// Iterative sign-magnitude Q(INT_W.FRAC_W) multiplier, one multiplier bit per clock.
// Define SM_MULT_SATURATE_EN to saturate the magnitude on overflow.
//
// state | meaning
// IDLE  | ready for an operand pair
// BUSY  | shift-add, one multiplier bit per cycle
// DONE  | result valid, waiting for out_ready
`timescale 1ns/1ps
module sm_fixed_mult_seq
    import fixed_mult_pkg::*;
#(
    parameter int INT_W  = 7,
    parameter int FRAC_W = 9,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     a_sign,
    input  logic [INT_W+FRAC_W-1:0]  a_mag,
    input  logic                     b_sign,
    input  logic [INT_W+FRAC_W-1:0]  b_mag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sign,
    output logic [OUT_W-1:0]         out_mag,
    output logic                     out_overflow
);

    localparam int MAG_W = INT_W + FRAC_W;
    localparam int PW    = 2 * MAG_W;
    localparam int CW    = (MAG_W > 1) ? $clog2(MAG_W) : 1;

    state_t            state, next_state;
    logic [MAG_W-1:0]  mcand, mplier;
    logic              sign_l;
    logic [PW-1:0]     acc, acc_next, partial;
    logic [CW-1:0]     cnt;
    logic              last;
    norm_t             norm;
    logic              unused_bits;

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        partial    = mplier[cnt] ? ({{MAG_W{1'b0}}, mcand} << cnt) : '0;
        acc_next   = acc + partial;
        last       = (cnt == CW'(MAG_W - 1));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = BUSY;
            end
            BUSY: begin
                if (last) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Final-cycle result is taken from acc_next so it lands on the same edge as the last add.
    always_comb begin
        norm = normalise(64'(acc_next[PW-1:FRAC_W]), OUT_W);
    end

    assign unused_bits = ^{norm.mag[63:OUT_W], acc_next[FRAC_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mcand        <= '0;
            mplier       <= '0;
            sign_l       <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            out_sign     <= 1'b0;
            out_mag      <= '0;
            out_overflow <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        sign_l <= a_sign ^ b_sign;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        out_sign     <= sign_l & (acc_next != '0);
                        out_mag      <= norm.mag[OUT_W-1:0];
                        out_overflow <= norm.ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_fixed_mult_seq.sv
// Self-checking bench for sm_fixed_mult_seq against an arithmetic reference model.
`timescale 1ns/1ps
module tb_sm_fixed_mult_seq;

    localparam int INT_W  = 7;
    localparam int FRAC_W = 9;
    localparam int OUT_W  = 16;
    localparam int MAG_W  = INT_W + FRAC_W;
`ifdef SM_MULT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             a_sign = 1'b0;
    logic [MAG_W-1:0] a_mag = '0;
    logic             b_sign = 1'b0;
    logic [MAG_W-1:0] b_mag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_sign;
    logic [OUT_W-1:0] out_mag;
    logic             out_overflow;

    int tests = 0;
    int fails = 0;

    sm_fixed_mult_seq #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .a_mag(a_mag), .b_sign(b_sign), .b_mag(b_mag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_mag(out_mag), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    // Product computed with plain integer arithmetic on the real-valued operands.
    function automatic void model(input bit as, input int unsigned am, input bit bs,
                                  input int unsigned bm,
                                  output bit es, output logic [OUT_W-1:0] em, output bit eo);
        longint unsigned p, r, lim;
        p   = longint'(am) * longint'(bm);
        r   = p / (64'd1 << FRAC_W);
        lim = 64'd1 << OUT_W;
        eo  = (r >= lim);
        em  = (eo && SAT) ? {OUT_W{1'b1}} : OUT_W'(r % lim);
        es  = (as != bs) && (p != 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair, scrambles the inputs after the accept, waits for out_valid.
    task automatic issue(input bit as, input int unsigned am, input bit bs, input int unsigned bm,
                         output int lat);
        in_valid = 1'b1;
        a_sign = as; a_mag = MAG_W'(am); b_sign = bs; b_mag = MAG_W'(bm);
        while (!in_ready) tick();
        tick();
        in_valid = 1'b0;
        a_sign = $urandom_range(1, 0) != 0; a_mag = MAG_W'($urandom);
        b_sign = $urandom_range(1, 0) != 0; b_mag = MAG_W'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string name, input bit as, input int unsigned am,
                                input bit bs, input int unsigned bm, input int lat);
        bit es, eo;
        logic [OUT_W-1:0] em;
        model(as, am, bs, bm, es, em, eo);
        tests++;
        if (lat !== MAG_W) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, MAG_W);
        end
        tests++;
        if (out_sign !== es || out_mag !== em || out_overflow !== eo) begin
            fails++;
            $display("FAIL %s result: got s=%0b m=%h o=%0b want s=%0b m=%h o=%0b",
                     name, out_sign, out_mag, out_overflow, es, em, eo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0 ||
            out_mag !== '0 || out_overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset: rdy=%0b vld=%0b s=%0b m=%h o=%0b want 1 0 0 0 0",
                     in_ready, out_valid, out_sign, out_mag, out_overflow);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset: rdy=%0b vld=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        int lat;
        out_ready = 1'b1;
        issue(1'b0, 512, 1'b1, 1280, lat);
        check_result("one_x_neg2p5", 1'b0, 512, 1'b1, 1280, lat);
        tick();
        issue(1'b1, 65024, 1'b1, 65024, lat);
        check_result("m127_sq", 1'b1, 65024, 1'b1, 65024, lat);
        tick();
        issue(1'b1, 0, 1'b0, 1536, lat);
        check_result("neg_zero", 1'b1, 0, 1'b0, 1536, lat);
        tick();
    endtask

    task automatic test_random();
        int lat;
        bit as, bs;
        int unsigned am, bm;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            as = $urandom_range(1, 0) != 0;
            bs = $urandom_range(1, 0) != 0;
            am = (i % 7 == 0) ? 0 : $urandom_range(65535, 0);
            bm = (i % 5 == 0) ? $urandom_range(2047, 0) : $urandom_range(65535, 0);
            issue(as, am, bs, bm, lat);
            check_result("random", as, am, bs, bm, lat);
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit es, eo;
        logic [OUT_W-1:0] em;
        out_ready = 1'b0;
        issue(1'b1, 3000, 1'b0, 777, lat);
        check_result("bp_first", 1'b1, 3000, 1'b0, 777, lat);
        model(1'b1, 3000, 1'b0, 777, es, em, eo);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a_mag = 16'd100; b_mag = 16'd100; a_sign = 1'b0; b_sign = 1'b0;
            tick();
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== es ||
                out_mag !== em || out_overflow !== eo) begin
                fails++;
                $display("FAIL bp_hold cyc%0d: vld=%0b rdy=%0b s=%0b m=%h want 1 0 %0b %h",
                         i, out_valid, in_ready, out_sign, out_mag, es, em);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sign !== es ||
            out_mag !== em || out_overflow !== eo) begin
            fails++;
            $display("FAIL bp_handoff: vld=%0b rdy=%0b s=%0b m=%h want 0 1 %0b %h",
                     out_valid, in_ready, out_sign, out_mag, es, em);
        end
    endtask

    task automatic test_reset_midbusy();
        int lat;
        bit rose = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; a_sign = 1'b0; a_mag = 16'd5000; b_sign = 1'b1; b_mag = 16'd6000;
        tick();
        in_valid = 1'b0;
        repeat (7) begin
            tick();
            if (out_valid) rose = 1'b1;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mag !== '0) begin
            fails++;
            $display("FAIL midbusy_reset: rdy=%0b vld=%0b m=%h want 1 0 0", in_ready, out_valid, out_mag);
        end
        repeat (20) begin
            tick();
            if (out_valid) rose = 1'b1;
        end
        tests++;
        if (rose !== 1'b0) begin
            fails++; $display("FAIL midbusy_no_valid: rose=%0b want 0", rose);
        end
        issue(1'b0, 1024, 1'b0, 1024, lat);
        check_result("two_x_two", 1'b0, 1024, 1'b0, 1024, lat);
        tick();
    endtask

    task automatic test_back_to_back();
        int last_acc = -1;
        int n_int = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; a_sign = 1'b0; a_mag = 16'd1234; b_sign = 1'b0; b_mag = 16'd4321;
        for (int c = 0; c < 60; c++) begin
            if (in_ready) begin
                if (last_acc >= 0) begin
                    tests++;
                    n_int++;
                    if (c - last_acc !== MAG_W + 2) begin
                        fails++;
                        $display("FAIL issue_interval: got %0d want %0d", c - last_acc, MAG_W + 2);
                    end
                end
                last_acc = c;
            end
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (n_int < 2) begin
            fails++; $display("FAIL issue_count: got %0d intervals want >=2", n_int);
        end
        repeat (25) tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midbusy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
